// File: rtl/ibram_arbiter_if.sv
// rtl/ibram_arbiter_if.sv - fetch/BRAM signal bundle for the dual-core instruction BRAM arbiter
//
// Purpose: groups both fetch sub-unit handshakes and the shared BRAM port.
// Modports:
//   slave  - arbiter view: takes fetch requests and BRAM read data, drives
//            ready/data_valid/data_out and the BRAM control lines.
//   master - environment view: fetch units plus BRAM, the mirror of slave.
// Signals:
//   fetchK_new_request, fetchK_addr, fetchK_flush  (fetch -> arbiter)
//   fetchK_ready, fetchK_data_valid, fetchK_data_out (arbiter -> fetch)
//   bram_en, bram_addr, bram_be, bram_data_in (arbiter -> BRAM)
//   bram_data_out (BRAM -> arbiter, one cycle after bram_en)
interface ibram_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              fetch0_new_request;
  logic [ADDR_W-1:0] fetch0_addr;
  logic              fetch0_flush;
  logic              fetch0_ready;
  logic              fetch0_data_valid;
  logic [DATA_W-1:0] fetch0_data_out;

  logic              fetch1_new_request;
  logic [ADDR_W-1:0] fetch1_addr;
  logic              fetch1_flush;
  logic              fetch1_ready;
  logic              fetch1_data_valid;
  logic [DATA_W-1:0] fetch1_data_out;

  logic                bram_en;
  logic [ADDR_W-1:0]   bram_addr;
  logic [DATA_W/8-1:0] bram_be;
  logic [DATA_W-1:0]   bram_data_in;
  logic [DATA_W-1:0]   bram_data_out;

  modport slave (
    input  fetch0_new_request, fetch0_addr, fetch0_flush,
    input  fetch1_new_request, fetch1_addr, fetch1_flush,
    input  bram_data_out,
    output fetch0_ready, fetch0_data_valid, fetch0_data_out,
    output fetch1_ready, fetch1_data_valid, fetch1_data_out,
    output bram_en, bram_addr, bram_be, bram_data_in
  );

  modport master (
    output fetch0_new_request, fetch0_addr, fetch0_flush,
    output fetch1_new_request, fetch1_addr, fetch1_flush,
    output bram_data_out,
    input  fetch0_ready, fetch0_data_valid, fetch0_data_out,
    input  fetch1_ready, fetch1_data_valid, fetch1_data_out,
    input  bram_en, bram_addr, bram_be, bram_data_in
  );
endinterface

// File: rtl/ibram_arbiter.sv
// rtl/ibram_arbiter.sv - round-robin share of one single-port instruction BRAM between two fetch units
//
// Purpose: two fetch sub-units read one BRAM. Same-cycle collisions are
// resolved round-robin; the loser is parked in a one-entry holding register
// and is granted the following cycle, so read latency is at most two cycles.
// Ports:
//   clk  - single clock, rising edge.
//   rst  - synchronous reset, active low (0 = reset).
//   bus  - ibram_arbiter_if.slave: both fetch handshakes and the BRAM port.
//   conflict_count, stall0_count, stall1_count - 32-bit wrapping event
//          counters, present only when IBRAM_ARB_PERF_EN is defined.
// Optional feature macro: IBRAM_ARB_PERF_EN.
module ibram_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  ibram_arbiter_if.slave      bus
`ifdef IBRAM_ARB_PERF_EN
  ,
  output logic [31:0]         conflict_count,
  output logic [31:0]         stall0_count,
  output logic [31:0]         stall1_count
`endif
);

  logic [1:0]        new_req;
  logic [1:0]        flush;
  logic [ADDR_W-1:0] in_addr     [2];

  logic [1:0]        req;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] cand_addr   [2];

  logic [1:0]        pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q [2];
  logic [ADDR_W-1:0] pend_addr_d [2];
  logic [1:0]        rvalid_q, rvalid_d;
  // 1 = port 1 was granted most recently, so port 0 wins the next collision.
  logic              last_grant_q, last_grant_d;

  always_comb begin
    new_req    = {bus.fetch1_new_request, bus.fetch0_new_request};
    flush      = {bus.fetch1_flush, bus.fetch0_flush};
    in_addr[0] = bus.fetch0_addr;
    in_addr[1] = bus.fetch1_addr;
  end

  // A parked request takes priority over the port's live inputs; a new
  // request raised while parked (ready low) is simply ignored. Flush masks
  // both the live and the parked request for this cycle.
  always_comb begin
    req  = '0;
    for (int k = 0; k < 2; k++) begin
      req[k]       = ~flush[k] & (pend_q[k] | new_req[k]);
      cand_addr[k] = pend_q[k] ? pend_addr_q[k] : in_addr[k];
    end
    grant    = '0;
    grant[0] = req[0] & (~req[1] |  last_grant_q);
    grant[1] = req[1] & (~req[0] | ~last_grant_q);
  end

  always_comb begin
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    rvalid_d     = '0;
    last_grant_d = last_grant_q;

    if (grant[1]) begin
      last_grant_d = 1'b1;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
    end

    for (int k = 0; k < 2; k++) begin
      rvalid_d[k] = grant[k] & ~flush[k];
      if (flush[k]) begin
        pend_d[k] = 1'b0;
      end else if (pend_q[k]) begin
        if (grant[k]) begin
          pend_d[k] = 1'b0;
        end
      end else if (req[k] && !grant[k]) begin
        // Accepted new request lost the collision: park it.
        pend_d[k]      = 1'b1;
        pend_addr_d[k] = in_addr[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q       <= '0;
      rvalid_q     <= '0;
      last_grant_q <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        pend_addr_q[k] <= '0;
      end
    end else begin
      pend_q       <= pend_d;
      rvalid_q     <= rvalid_d;
      last_grant_q <= last_grant_d;
      for (int k = 0; k < 2; k++) begin
        pend_addr_q[k] <= pend_addr_d[k];
      end
    end
  end

  assign bus.bram_en      = |grant;
  assign bus.bram_addr    = grant[1] ? cand_addr[1] : cand_addr[0];
  assign bus.bram_be      = '0;
  assign bus.bram_data_in = '0;

  assign bus.fetch0_ready = ~pend_q[0];
  assign bus.fetch1_ready = ~pend_q[1];

  // A flush in the response cycle discards the read that is already in flight.
  assign bus.fetch0_data_valid = rvalid_q[0] & ~flush[0];
  assign bus.fetch1_data_valid = rvalid_q[1] & ~flush[1];
  assign bus.fetch0_data_out   = bus.bram_data_out;
  assign bus.fetch1_data_out   = bus.bram_data_out;

`ifdef IBRAM_ARB_PERF_EN
  logic [31:0] conflict_q, conflict_d;
  logic [31:0] stall0_q, stall0_d;
  logic [31:0] stall1_q, stall1_d;

  always_comb begin
    conflict_d = conflict_q + {31'd0, &req};
    stall0_d   = stall0_q + {31'd0, pend_q[0]};
    stall1_d   = stall1_q + {31'd0, pend_q[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_q <= '0;
      stall0_q   <= '0;
      stall1_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      stall0_q   <= stall0_d;
      stall1_q   <= stall1_d;
    end
  end

  assign conflict_count = conflict_q;
  assign stall0_count   = stall0_q;
  assign stall1_count   = stall1_q;
`endif

endmodule

// File: tb/tb_ibram_arbiter.sv
// tb/tb_ibram_arbiter.sv - self-checking bench for ibram_arbiter
module tb_ibram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ibram_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  ibram_arbiter #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] memf(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  logic [31:0] bram_q;
  always @(posedge clk) begin
    if (bus.bram_en) bram_q <= memf(bus.bram_addr);
  end
  assign bus.bram_data_out = bram_q;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model state, indexed by port.
  logic        m_pend   [2];
  logic [29:0] m_paddr  [2];
  logic        m_rv     [2];
  logic [29:0] m_rvaddr [2];
  logic        m_last;
  int          m_w;
  logic        m_c      [2];
  logic [29:0] m_ca     [2];
  logic        model_on;

  logic        rs;
  logic        nr [2];
  logic [29:0] ad [2];
  logic        fl [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; m_paddr[k] = '0; m_rv[k] = 1'b0; m_rvaddr[k] = '0;
    end
    m_last = 1'b1;
  endtask

  task automatic apply(input logic r, input logic n0, input logic [29:0] a0, input logic f0,
                       input logic n1, input logic [29:0] a1, input logic f1);
    logic dv [2];
    logic rdy [2];
    logic [31:0] dout [2];
    @(negedge clk);
    rs = r; nr[0] = n0; ad[0] = a0; fl[0] = f0; nr[1] = n1; ad[1] = a1; fl[1] = f1;
    rst = r;
    bus.fetch0_new_request = n0; bus.fetch0_addr = a0; bus.fetch0_flush = f0;
    bus.fetch1_new_request = n1; bus.fetch1_addr = a1; bus.fetch1_flush = f1;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_c[k]  = !fl[k] && (m_pend[k] || nr[k]);
      m_ca[k] = m_pend[k] ? m_paddr[k] : ad[k];
    end
    if (m_c[0] && m_c[1]) m_w = m_last ? 0 : 1;
    else if (m_c[0])      m_w = 0;
    else if (m_c[1])      m_w = 1;
    else                  m_w = -1;
    if (model_on) begin
      dv[0] = bus.fetch0_data_valid;  dv[1] = bus.fetch1_data_valid;
      rdy[0] = bus.fetch0_ready;      rdy[1] = bus.fetch1_ready;
      dout[0] = bus.fetch0_data_out;  dout[1] = bus.fetch1_data_out;
      chk("model_bram_en", 64'(bus.bram_en), 64'(m_w >= 0));
      if (m_w >= 0) chk("model_bram_addr", 64'(bus.bram_addr), 64'(m_ca[m_w]));
      chk("model_bram_be", 64'(bus.bram_be), 64'd0);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_ready%0d", k), 64'(rdy[k]), 64'(!m_pend[k]));
        chk($sformatf("model_valid%0d", k), 64'(dv[k]), 64'(m_rv[k] && !fl[k]));
        if (m_rv[k] && !fl[k])
          chk($sformatf("model_data%0d", k), 64'(dout[k]), 64'(memf(m_rvaddr[k])));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rs) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_rv[k]     = (m_w == k);
        m_rvaddr[k] = m_ca[k];
        if (fl[k] || (m_w == k)) m_pend[k] = 1'b0;
        else if (m_c[k] && !m_pend[k]) begin
          m_pend[k]  = 1'b1;
          m_paddr[k] = ad[k];
        end
      end
      if (m_w >= 0) m_last = (m_w == 1);
    end
  endtask

  typedef struct {
    logic rst, n0; logic [29:0] a0; logic f0, n1; logic [29:0] a1; logic f1;
    logic en; logic [29:0] addr; logic r0, r1, v0, v1; logic [29:0] da;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic n0, input logic [29:0] a0, input logic f0,
                              input logic n1, input logic [29:0] a1, input logic f1,
                              input logic en, input logic [29:0] addr, input logic r0, input logic r1,
                              input logic v0, input logic v1, input logic [29:0] da);
    vec_t v;
    v.rst = r; v.n0 = n0; v.a0 = a0; v.f0 = f0; v.n1 = n1; v.a1 = a1; v.f1 = f1;
    v.en = en; v.addr = addr; v.r0 = r0; v.r1 = r1; v.v0 = v0; v.v1 = v1; v.da = da;
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    int g;
    int cnt0, cnt1;
    logic [29:0] na [2];
    logic [29:0] q0 [$];
    logic [29:0] q1 [$];

    tbl[0]  = mk(0, 0,0,0, 0,0,0,       0,0,      1,1, 0,0, 0);
    tbl[1]  = mk(1, 1,'h10,0, 0,0,0,    1,'h10,   1,1, 0,0, 0);
    tbl[2]  = mk(1, 0,0,0, 0,0,0,       0,0,      1,1, 1,0, 'h10);
    tbl[3]  = mk(0, 0,0,0, 0,0,0,       0,0,      1,1, 0,0, 0);
    tbl[4]  = mk(1, 1,'h20,0, 1,'h40,0, 1,'h20,   1,1, 0,0, 0);
    tbl[5]  = mk(1, 0,0,0, 0,0,0,       1,'h40,   1,0, 1,0, 'h20);
    tbl[6]  = mk(1, 0,0,0, 0,0,0,       0,0,      1,1, 0,1, 'h40);
    tbl[7]  = mk(1, 1,'h50,0, 1,'h60,0, 1,'h50,   1,1, 0,0, 0);
    tbl[8]  = mk(1, 0,0,0, 0,0,1,       0,0,      1,0, 1,0, 'h50);
    tbl[9]  = mk(1, 0,0,0, 0,0,0,       0,0,      1,1, 0,0, 0);
    tbl[10] = mk(1, 1,'h70,0, 0,0,0,    1,'h70,   1,1, 0,0, 0);
    tbl[11] = mk(1, 0,0,1, 0,0,0,       0,0,      1,1, 0,0, 0);
    tbl[12] = mk(1, 0,0,0, 0,0,0,       0,0,      1,1, 0,0, 0);
    tbl[13] = mk(1, 1,'h74,1, 0,0,0,    0,0,      1,1, 0,0, 0);
    tbl[14] = mk(1, 0,0,0, 0,0,0,       0,0,      1,1, 0,0, 0);
    tbl[15] = mk(1, 1,'h80,0, 1,'h90,0, 1,'h90,   1,1, 0,0, 0);
    tbl[16] = mk(0, 0,0,0, 0,0,0,       1,'h80,   0,1, 0,1, 'h90);
    tbl[17] = mk(1, 0,0,0, 0,0,0,       0,0,      1,1, 0,0, 0);
    tbl[18] = mk(1, 1,'hA0,0, 1,'hB0,0, 1,'hA0,   1,1, 0,0, 0);
    tbl[19] = mk(1, 0,0,0, 0,0,0,       1,'hB0,   1,0, 1,0, 'hA0);
    tbl[20] = mk(1, 0,0,0, 0,0,0,       0,0,      1,1, 0,1, 'hB0);
    tbl[21] = mk(1, 0,0,0, 0,0,0,       0,0,      1,1, 0,0, 0);

    model_reset();
    model_on = 1'b0;
    apply(0, 0,0,0, 0,0,0); tick();
    apply(0, 0,0,0, 0,0,0); tick();
    model_on = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].rst, tbl[i].n0, tbl[i].a0, tbl[i].f0, tbl[i].n1, tbl[i].a1, tbl[i].f1);
      chk($sformatf("tbl%0d_en", i), 64'(bus.bram_en), 64'(tbl[i].en));
      if (tbl[i].en) chk($sformatf("tbl%0d_addr", i), 64'(bus.bram_addr), 64'(tbl[i].addr));
      chk($sformatf("tbl%0d_rdy0", i), 64'(bus.fetch0_ready), 64'(tbl[i].r0));
      chk($sformatf("tbl%0d_rdy1", i), 64'(bus.fetch1_ready), 64'(tbl[i].r1));
      chk($sformatf("tbl%0d_v0", i), 64'(bus.fetch0_data_valid), 64'(tbl[i].v0));
      chk($sformatf("tbl%0d_v1", i), 64'(bus.fetch1_data_valid), 64'(tbl[i].v1));
      if (tbl[i].v0) chk($sformatf("tbl%0d_d0", i), 64'(bus.fetch0_data_out), 64'(memf(tbl[i].da)));
      if (tbl[i].v1) chk($sformatf("tbl%0d_d1", i), 64'(bus.fetch1_data_out), 64'(memf(tbl[i].da)));
      tick();
    end

    // Saturated collisions: both ports issue whenever ready, for 8 cycles.
    na[0] = 30'h100; na[1] = 30'h200;
    cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 10; c++) begin
      logic n0, n1;
      n0 = (c < 8) && !m_pend[0];
      n1 = (c < 8) && !m_pend[1];
      apply(1, n0, na[0], 0, n1, na[1], 0);
      if (n0) begin q0.push_back(na[0]); na[0] = na[0] + 1; end
      if (n1) begin q1.push_back(na[1]); na[1] = na[1] + 1; end
      if (c < 8) begin
        chk($sformatf("alt%0d_en", c), 64'(bus.bram_en), 64'd1);
        g = bus.bram_addr[9] ? 1 : 0;
        chk($sformatf("alt%0d_grant", c), 64'(g), 64'(c % 2));
      end
      if (bus.fetch0_data_valid) begin
        if (c >= 1 && c <= 8) cnt0++;
        chk("alt_d0", 64'(bus.fetch0_data_out), 64'(memf(q0.pop_front())));
      end
      if (bus.fetch1_data_valid) begin
        if (c >= 1 && c <= 8) cnt1++;
        chk("alt_d1", 64'(bus.fetch1_data_out), 64'(memf(q1.pop_front())));
      end
      tick();
    end
    chk("alt_count0", 64'(cnt0), 64'd4);
    chk("alt_count1", 64'(cnt1), 64'd4);
    chk("alt_lost0", 64'(q0.size()), 64'd0);
    chk("alt_lost1", 64'(q1.size()), 64'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      logic r, n0, n1, f0, f1;
      r  = ($urandom_range(0, 39) != 0);
      n0 = m_pend[0] ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
      n1 = m_pend[1] ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
      f0 = ($urandom_range(0, 9) == 0);
      f1 = ($urandom_range(0, 9) == 0);
      apply(r, n0, 30'($urandom), f0, n1, 30'($urandom), f1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
